// File: rtl/voice_pkg.sv
// Shared constants, FSM state encoding and message layout for the voice allocator.
package voice_pkg;

  localparam int VOICES = 4;
  localparam int NOTE_W = 7;
  localparam int AGE_W  = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_APPLY = 2'd2;

  // Rank operations: ALLOC pushes every other active slot back, TOUCH only those
  // newer than the target (retrigger and steal), RELEASE closes the gap it leaves.
  localparam logic [1:0] OP_NONE    = 2'd0;
  localparam logic [1:0] OP_ALLOC   = 2'd1;
  localparam logic [1:0] OP_TOUCH   = 2'd2;
  localparam logic [1:0] OP_RELEASE = 2'd3;

  typedef struct packed {
    logic              on;
    logic [NOTE_W-1:0] note;
    logic [NOTE_W-1:0] vel;
  } voice_msg_t;

endpackage

// File: rtl/voice_age_ctrl.sv
// Per-slot age ranks (0 = newest); updated in one ce-cycle from an op code and target slot.
module voice_age_ctrl
  import voice_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ce,
  input  logic [1:0]                op,
  input  logic [1:0]                slot,
  input  logic [VOICES-1:0]         active,
  output logic [VOICES*AGE_W-1:0]   ages
);

  logic [AGE_W-1:0] age_q [VOICES];
  logic [AGE_W-1:0] ref_age;

  assign ref_age = age_q[slot];

  // The target always becomes newest; inactive slots are never touched, so they stay at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < VOICES; i++) age_q[i] <= '0;
    end else if (ce && op != OP_NONE) begin
      for (int i = 0; i < VOICES; i++) begin
        if (2'(i) == slot) begin
          age_q[i] <= '0;
        end else if (active[i]) begin
          case (op)
            OP_ALLOC:   age_q[i] <= age_q[i] + 1'b1;
            OP_TOUCH:   if (age_q[i] < ref_age) age_q[i] <= age_q[i] + 1'b1;
            OP_RELEASE: if (age_q[i] > ref_age) age_q[i] <= age_q[i] - 1'b1;
            default:    ;
          endcase
        end
      end
    end
  end

  for (genvar g = 0; g < VOICES; g++) begin : g_pack
    assign ages[g*AGE_W +: AGE_W] = age_q[g];
  end

endmodule

// File: rtl/voice_alloc.sv
// Four-slot polyphonic voice allocator: IDLE -> 4-cycle slot scan -> APPLY, with oldest-voice stealing.
module voice_alloc
  import voice_pkg::*;
#(
  parameter bit RETRIG_EN = 1'b1,
  parameter int SCAN_LEN  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              msg_valid,
  output logic              msg_ready,
  input  logic              msg_on,
  input  logic [NOTE_W-1:0] msg_note,
  input  logic [NOTE_W-1:0] msg_vel,
  output logic [NOTE_W-1:0] note_num_0,
  output logic [NOTE_W-1:0] note_num_1,
  output logic [NOTE_W-1:0] note_num_2,
  output logic [NOTE_W-1:0] note_num_3,
  output logic [NOTE_W-1:0] note_vel_0,
  output logic [NOTE_W-1:0] note_vel_1,
  output logic [NOTE_W-1:0] note_vel_2,
  output logic [NOTE_W-1:0] note_vel_3,
  output logic [VOICES-1:0] voice_active,
  output logic              steal
);

  localparam logic [1:0] LAST_IDX = 2'(SCAN_LEN - 1);

  logic [1:0]          state;
  logic [1:0]          idx;
  voice_msg_t          msg_q;
  logic [NOTE_W-1:0]   num_q [VOICES];
  logic [NOTE_W-1:0]   vel_q [VOICES];
  logic [VOICES-1:0]   active_q;
  logic                steal_q;
  logic                match_found, free_found;
  logic [1:0]          match_idx, free_idx, oldest_idx;
  logic [VOICES*AGE_W-1:0] ages;
  logic [AGE_W-1:0]    scan_age;

  logic [1:0]          op, tgt;
  logic                wr_num, wr_vel, set_act, clr_act, do_steal;
  logic [NOTE_W-1:0]   new_vel;

  assign scan_age  = ages[{idx, 1'b0} +: AGE_W];
  assign msg_ready = (state == ST_IDLE);
  assign new_vel   = msg_q.on ? msg_q.vel : '0;

  // Controller: a zero-velocity note-on is folded into a note-off at accept time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      msg_q       <= '0;
      match_found <= 1'b0;
      free_found  <= 1'b0;
      match_idx   <= '0;
      free_idx    <= '0;
      oldest_idx  <= '0;
    end else if (ce) begin
      case (state)
        ST_IDLE: begin
          if (msg_valid) begin
            msg_q.on    <= msg_on && (msg_vel != '0);
            msg_q.note  <= msg_note;
            msg_q.vel   <= msg_vel;
            idx         <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            state       <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (active_q[idx]) begin
            if (!match_found && num_q[idx] == msg_q.note) begin
              match_found <= 1'b1;
              match_idx   <= idx;
            end
            if (scan_age == AGE_W'(VOICES - 1)) oldest_idx <= idx;
          end else if (!free_found) begin
            free_found <= 1'b1;
            free_idx   <= idx;
          end
          if (idx == LAST_IDX) state <= ST_APPLY;
          else idx <= idx + 1'b1;
        end
        ST_APPLY: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Decide the APPLY action from the scan results.
  always_comb begin
    op       = OP_NONE;
    tgt      = match_idx;
    wr_num   = 1'b0;
    wr_vel   = 1'b0;
    set_act  = 1'b0;
    clr_act  = 1'b0;
    do_steal = 1'b0;
    if (state == ST_APPLY) begin
      if (msg_q.on) begin
        if (match_found && RETRIG_EN) begin
          op     = OP_TOUCH;
          wr_vel = 1'b1;
        end else if (free_found) begin
          op      = OP_ALLOC;
          tgt     = free_idx;
          wr_num  = 1'b1;
          wr_vel  = 1'b1;
          set_act = 1'b1;
        end else begin
          op       = OP_TOUCH;
          tgt      = oldest_idx;
          wr_num   = 1'b1;
          wr_vel   = 1'b1;
          do_steal = 1'b1;
        end
      end else if (match_found) begin
        op      = OP_RELEASE;
        wr_vel  = 1'b1;
        clr_act = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < VOICES; i++) begin
        num_q[i] <= '0;
        vel_q[i] <= '0;
      end
      active_q <= '0;
      steal_q  <= 1'b0;
    end else if (ce) begin
      if (wr_num)  num_q[tgt]    <= msg_q.note;
      if (wr_vel)  vel_q[tgt]    <= new_vel;
      if (set_act) active_q[tgt] <= 1'b1;
      if (clr_act) active_q[tgt] <= 1'b0;
      steal_q <= do_steal;
    end
  end

  voice_age_ctrl u_age (
    .clk    (clk),
    .rst    (rst),
    .ce     (ce),
    .op     (op),
    .slot   (tgt),
    .active (active_q),
    .ages   (ages)
  );

  assign note_num_0   = num_q[0];
  assign note_num_1   = num_q[1];
  assign note_num_2   = num_q[2];
  assign note_num_3   = num_q[3];
  assign note_vel_0   = vel_q[0];
  assign note_vel_1   = vel_q[1];
  assign note_vel_2   = vel_q[2];
  assign note_vel_3   = vel_q[3];
  assign voice_active = active_q;
  assign steal        = steal_q;

endmodule

// File: tb/tb_voice_alloc.sv
// Bench for voice_alloc: a RETRIG_EN=1 and a RETRIG_EN=0 instance share stimulus and are checked against a timestamp model.
module tb_voice_alloc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce  = 1'b1;
  logic       msg_valid = 1'b0;
  logic       msg_on    = 1'b0;
  logic [6:0] msg_note  = '0;
  logic [6:0] msg_vel   = '0;

  logic       rdy_a, rdy_b, st_a, st_b;
  logic [3:0] act_a, act_b;
  logic [6:0] num_a [4], vel_a [4], num_b [4], vel_b [4];

  int checks = 0;
  int passed = 0;

  voice_alloc #(.RETRIG_EN(1'b1), .SCAN_LEN(4)) dut_a (
    .clk(clk), .rst(rst), .ce(ce), .msg_valid(msg_valid), .msg_ready(rdy_a),
    .msg_on(msg_on), .msg_note(msg_note), .msg_vel(msg_vel),
    .note_num_0(num_a[0]), .note_num_1(num_a[1]), .note_num_2(num_a[2]), .note_num_3(num_a[3]),
    .note_vel_0(vel_a[0]), .note_vel_1(vel_a[1]), .note_vel_2(vel_a[2]), .note_vel_3(vel_a[3]),
    .voice_active(act_a), .steal(st_a)
  );

  voice_alloc #(.RETRIG_EN(1'b0), .SCAN_LEN(4)) dut_b (
    .clk(clk), .rst(rst), .ce(ce), .msg_valid(msg_valid), .msg_ready(rdy_b),
    .msg_on(msg_on), .msg_note(msg_note), .msg_vel(msg_vel),
    .note_num_0(num_b[0]), .note_num_1(num_b[1]), .note_num_2(num_b[2]), .note_num_3(num_b[3]),
    .note_vel_0(vel_b[0]), .note_vel_1(vel_b[1]), .note_vel_2(vel_b[2]), .note_vel_3(vel_b[3]),
    .voice_active(act_b), .steal(st_b)
  );

  always #5 clk = ~clk;

  // Model: per instance, slots with a timestamp of last (re)assignment; oldest = smallest stamp.
  logic [6:0] m_num   [2][4];
  logic [6:0] m_vel   [2][4];
  bit         m_act   [2][4];
  longint     m_stamp [2][4];
  bit         m_steal [2];
  longint     tick = 0;
  int         busy = 0;
  bit         acc_flag = 1'b0;
  bit         p_on;
  logic [6:0] p_note, p_vel;
  bit         ce_mode = 1'b0;
  int         ce_cnt = 0;

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_steal[m] = 1'b0;
      for (int i = 0; i < 4; i++) begin
        m_num[m][i] = '0; m_vel[m][i] = '0; m_act[m][i] = 1'b0; m_stamp[m][i] = 0;
      end
    end
    busy = 0;
  endtask

  task automatic apply_msg(input int m, input bit on, input logic [6:0] note, input logic [6:0] vel);
    int match = -1;
    int free = -1;
    int old = -1;
    if (vel == 0) on = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (m_act[m][i] && m_num[m][i] == note && match < 0) match = i;
      if (!m_act[m][i] && free < 0) free = i;
      if (m_act[m][i] && (old < 0 || m_stamp[m][i] < m_stamp[m][old])) old = i;
    end
    tick++;
    if (on) begin
      if (match >= 0 && m == 0) begin
        m_vel[m][match] = vel; m_stamp[m][match] = tick;
      end else if (free >= 0) begin
        m_num[m][free] = note; m_vel[m][free] = vel; m_act[m][free] = 1'b1; m_stamp[m][free] = tick;
      end else begin
        m_num[m][old] = note; m_vel[m][old] = vel; m_stamp[m][old] = tick; m_steal[m] = 1'b1;
      end
    end else if (match >= 0) begin
      m_act[m][match] = 1'b0; m_vel[m][match] = '0;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    acc_flag = 1'b0;
    if (rst) begin
      model_reset();
    end else if (ce) begin
      m_steal[0] = 1'b0;
      m_steal[1] = 1'b0;
      if (busy > 0) begin
        busy--;
        if (busy == 0) begin
          apply_msg(0, p_on, p_note, p_vel);
          apply_msg(1, p_on, p_note, p_vel);
        end
      end else if (msg_valid) begin
        p_on = msg_on; p_note = msg_note; p_vel = msg_vel;
        busy = 5;
        acc_flag = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    ce_cnt++;
    ce = ce_mode ? (ce_cnt % 3 == 0) : 1'b1;
  end

  task automatic compare(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("[TB] FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
  endtask

  // Every-cycle comparison of all outputs of both instances against the model.
  always @(negedge clk) begin
    logic [61:0] got, exp;
    for (int m = 0; m < 2; m++) begin
      exp = '0;
      exp[61] = (busy == 0);
      exp[60] = m_steal[m];
      for (int i = 0; i < 4; i++) begin
        exp[56+i] = m_act[m][i];
        exp[28+7*i +: 7] = m_num[m][i];
        exp[7*i +: 7] = m_vel[m][i];
      end
      if (m == 0)
        got = {rdy_a, st_a, act_a, num_a[3], num_a[2], num_a[1], num_a[0],
               vel_a[3], vel_a[2], vel_a[1], vel_a[0]};
      else
        got = {rdy_b, st_b, act_b, num_b[3], num_b[2], num_b[1], num_b[0],
               vel_b[3], vel_b[2], vel_b[1], vel_b[0]};
      compare(m == 0 ? "cycle_a" : "cycle_b", 64'(got), 64'(exp));
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (busy != 0 && k < 400) begin
      @(posedge clk); #1; k++;
    end
    compare("idle_timeout", 64'(busy == 0), 64'd1);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input bit on, input logic [6:0] note, input logic [6:0] vel, input bit wait_done);
    bit got_acc = 1'b0;
    msg_on = on; msg_note = note; msg_vel = vel; msg_valid = 1'b1;
    for (int k = 0; k < 80 && !got_acc; k++) begin
      @(posedge clk); #1;
      got_acc = acc_flag;
    end
    msg_valid = 1'b0;
    compare("accept_timeout", 64'(got_acc), 64'd1);
    if (wait_done) wait_idle();
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    compare(name, got, exp);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_active", 64'(act_a), 64'd0);
    checkOutput("rst_ready", 64'(rdy_a), 64'd1);
    checkOutput("rst_steal", 64'(st_a), 64'd0);

    applyStimulus(1'b1, 7'd60, 7'd100, 1'b1);
    checkOutput("first_num0", 64'(num_a[0]), 64'd60);
    checkOutput("first_vel0", 64'(vel_a[0]), 64'd100);
    checkOutput("first_active", 64'(act_a), 64'b0001);

    do_reset();
    applyStimulus(1'b1, 7'd60, 7'd80, 1'b1);
    applyStimulus(1'b1, 7'd62, 7'd80, 1'b1);
    applyStimulus(1'b1, 7'd64, 7'd80, 1'b1);
    applyStimulus(1'b1, 7'd67, 7'd80, 1'b1);
    checkOutput("full_active", 64'(act_a), 64'b1111);
    checkOutput("full_num3", 64'(num_a[3]), 64'd67);
    applyStimulus(1'b1, 7'd72, 7'd90, 1'b1);
    checkOutput("steal_pulse", 64'(st_a), 64'd1);
    checkOutput("steal_num0", 64'(num_a[0]), 64'd72);
    checkOutput("steal_vel0", 64'(vel_a[0]), 64'd90);
    @(negedge clk);
    checkOutput("steal_cleared", 64'(st_a), 64'd0);

    applyStimulus(1'b0, 7'd64, 7'd0, 1'b1);
    checkOutput("off_vel2", 64'(vel_a[2]), 64'd0);
    checkOutput("off_num2", 64'(num_a[2]), 64'd64);
    checkOutput("off_active", 64'(act_a), 64'b1011);
    applyStimulus(1'b1, 7'd50, 7'd70, 1'b1);
    checkOutput("refill_num2", 64'(num_a[2]), 64'd50);
    checkOutput("refill_steal", 64'(st_a), 64'd0);
    applyStimulus(1'b1, 7'd80, 7'd10, 1'b1);
    checkOutput("steal2_num1", 64'(num_a[1]), 64'd80);
    applyStimulus(1'b1, 7'd81, 7'd11, 1'b1);
    checkOutput("steal3_num3", 64'(num_a[3]), 64'd81);

    do_reset();
    applyStimulus(1'b1, 7'd60, 7'd100, 1'b1);
    applyStimulus(1'b1, 7'd60, 7'd0, 1'b1);
    checkOutput("vel0_off_active", 64'(act_a), 64'd0);
    checkOutput("vel0_off_vel0", 64'(vel_a[0]), 64'd0);
    applyStimulus(1'b0, 7'd61, 7'd0, 1'b1);
    checkOutput("empty_off_num0", 64'(num_a[0]), 64'd60);

    do_reset();
    applyStimulus(1'b1, 7'd60, 7'd100, 1'b1);
    applyStimulus(1'b1, 7'd62, 7'd100, 1'b1);
    applyStimulus(1'b1, 7'd60, 7'd40, 1'b1);
    checkOutput("retrig_vel0", 64'(vel_a[0]), 64'd40);
    checkOutput("retrig_vel1", 64'(vel_a[1]), 64'd100);
    checkOutput("retrig_active", 64'(act_a), 64'b0011);
    checkOutput("noretrig_num2", 64'(num_b[2]), 64'd60);
    checkOutput("noretrig_vel2", 64'(vel_b[2]), 64'd40);
    checkOutput("noretrig_active", 64'(act_b), 64'b0111);
    applyStimulus(1'b0, 7'd60, 7'd0, 1'b1);
    checkOutput("dup_off_b", 64'(act_b), 64'b0110);
    checkOutput("dup_off_a", 64'(act_a), 64'b0010);

    ce_mode = 1'b1;
    applyStimulus(1'b1, 7'd65, 7'd33, 1'b1);
    ce_mode = 1'b0;
    checkOutput("ce_num0_a", 64'(num_a[0]), 64'd65);
    checkOutput("ce_num0_b", 64'(num_b[0]), 64'd65);

    applyStimulus(1'b1, 7'd70, 7'd1, 1'b0);
    applyStimulus(1'b1, 7'd71, 7'd2, 1'b1);
    checkOutput("b2b_num2_a", 64'(num_a[2]), 64'd70);
    checkOutput("b2b_num3_a", 64'(num_a[3]), 64'd71);
    checkOutput("b2b_num3_b", 64'(num_b[3]), 64'd70);
    checkOutput("b2b_steal_b", 64'(num_b[1]), 64'd71);

    applyStimulus(1'b1, 7'd90, 7'd20, 1'b0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checkOutput("midscan_active", 64'(act_a), 64'd0);
    checkOutput("midscan_num", 64'({num_a[3], num_a[2], num_a[1], num_a[0]}), 64'd0);
    checkOutput("midscan_vel", 64'({vel_a[3], vel_a[2], vel_a[1], vel_a[0]}), 64'd0);
    checkOutput("midscan_ready", 64'(rdy_a), 64'd1);
    @(posedge clk); #1 rst = 1'b0;
    applyStimulus(1'b1, 7'd44, 7'd55, 1'b1);
    checkOutput("post_rst_num0", 64'(num_a[0]), 64'd44);
    checkOutput("post_rst_active", 64'(act_a), 64'b0001);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/voice_alloc.md
Name: voice_alloc

Overview:
Polyphonic voice allocator that turns a stream of note-on/note-off messages into the four static voice slots consumed by the NCO bank. It drives note_num_0..3 and note_vel_0..3, which connect directly to the bank's same-named inputs. It holds per-slot age ranks and steals the oldest voice when all four slots are busy. Sits between the MIDI message parser and nco_bank, in the same clk/ce domain.

Parameters:
RETRIG_EN, 1, 1 = note-on for an already-sounding note reuses its slot; 0 = always allocate a new slot
SCAN_LEN, 4, voice count; fixed at 4 to match the port list, and any other value is illegal

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
ce  in  1  clock enable; all state advances only when ce=1
msg_valid  in  1  message present
msg_ready  out  1  allocator can accept a message
msg_on  in  1  1 = note-on, 0 = note-off
msg_note  in  7  MIDI note number
msg_vel  in  7  MIDI velocity
note_num_0..note_num_3  out  7 each  slot note number, to nco_bank
note_vel_0..note_vel_3  out  7 each  slot velocity, to nco_bank; 0 = silent
voice_active  out  4  bit i = slot i sounding
steal  out  1  one-ce-cycle pulse when a sounding voice is overwritten

Behaviour:
- Reset (async):
  - all note_num and note_vel = 0; voice_active = 0; all ages = 0.
  - steal = 0; msg_ready = 1; state = IDLE.
  - An in-flight message is discarded.
- Freeze: ce=0 freezes all state and outputs.
- Accept: on msg_valid & msg_ready & ce, latch msg_on, msg_note and msg_vel. A note-on with vel=0 is converted to a note-off.
- FSM:
  - IDLE (msg_ready=1) -> SCAN on accept.
  - SCAN: 4 ce-cycles, index i = 0..3, registered compare of slot i. Records:
    - match = lowest i with active & note_num_i == note.
    - free = lowest i with !active.
    - oldest = the i with age_i == 3.
  - SCAN -> APPLY after i=3.
  - APPLY: 1 ce-cycle that updates outputs, then -> IDLE.
- Latency: with continuous ce, msg_ready is low for exactly 5 cycles after the accept edge. Outputs change on the APPLY edge (accept edge + 5), and msg_ready returns to 1 in that same cycle.
- Age invariant: ages of active slots form a permutation of 0..k-1 (k = number of active slots), where 0 = newest. Inactive slots have age 0.
- APPLY rules, note-on:
  - Match found and RETRIG_EN=1, slot s with age a: note_vel_s = vel. Active slots with age < a get +1. age_s = 0. steal = 0.
  - Otherwise, if a free slot f exists: note_num_f = note, note_vel_f = vel, active_f = 1. All other active slots get age +1. age_f = 0.
  - Otherwise (all 4 active): steal the oldest slot o. Write note/vel into o. All other slots get age +1. age_o = 0. steal = 1 for the APPLY cycle only.
- APPLY rules, note-off:
  - Match found, slot s with age a: active_s = 0, note_vel_s = 0, note_num_s retained, age_s = 0. Active slots with age > a get -1.
  - No match: no change to any output.
- With RETRIG_EN=0, a duplicate note-on takes a free slot or steals; two slots may then hold the same note. A note-off then releases the lowest-index match only.
- Ages never exceed 3; increments apply only to active slots.
- No message is lost: msg_valid held while msg_ready=0 is accepted on return to IDLE.

Decomposition:
- Package voice_pkg holds:
  - localparams VOICES = 4, NOTE_W = 7, AGE_W = 2.
  - The FSM state encoding (IDLE, SCAN, APPLY).
  - The message struct fields (on, note, vel).
- One natural sub-module, voice_age_ctrl. It holds the 4x2-bit age ranks and performs the alloc/retrig/release/steal rank updates given a slot index and an operation code. This keeps the top level to the FSM, scan comparators and slot registers.

Test Plan:
- Reset then on(60,100) -> after 5 cycles: note_num_0=60, note_vel_0=100, voice_active=0001, steal=0, msg_ready back to 1.
- on 60, 62, 64, 67 (vel 80) -> slots 0..3 hold 60/62/64/67, voice_active=1111, ages 3/2/1/0. A further on(72,90) -> slot 0 = 72/90, steal pulses exactly 1 cycle, ages 0/3/2/1.
- From the four-voice state, off(64) -> note_vel_2=0, note_num_2=64 retained, voice_active=1011, ages 2/1/0/0. Then on(50,70) -> slot 2 = 50/70, steal=0.
- on(60,100) then on(60,0) -> treated as note-off: voice_active=0000, note_vel_0=0. off(61) on an empty bank -> no output change.
- RETRIG_EN=1: on 60, on 62, on(60,40) -> slot 0 vel=40, slot 1 unchanged, ages 0/1. RETRIG_EN=0: same sequence -> slot 2 = 60/40.
- ce toggled 1-of-3 during a message -> same final state, just stretched. Assert rst during SCAN -> all outputs 0 immediately, msg_ready=1, and the next message lands in slot 0.
